// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV64M multiply/divide unit, radix-2 iterative, valid/ready on both sides
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [2:0]          op_q, op_d;
    logic                word_q, word_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [XLEN-1:0]     ma_q, ma_d;
    logic [XLEN-1:0]     mb_q, mb_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r = XLEN'(v);
        if (v[31]) begin
            r = r | ~XLEN'(32'hFFFF_FFFF);
        end
        return r;
    endfunction

    // Operand preparation for the accept cycle
    logic            word_eff;
    logic            a_signed, b_signed, div_signed;
    logic [XLEN-1:0] a_ext, b_ext;
    logic            neg_a, neg_b;
    logic            b_zero, b_ones, a_min;
    logic            fast_dz, fast_ov;

    always_comb begin
        word_eff   = (XLEN == 64) && is_word;
        div_signed = (op == OP_DIV) || (op == OP_REM);
        a_signed   = (op == OP_MULH) || (op == OP_MULHSU) || div_signed;
        b_signed   = (op == OP_MULH) || div_signed;
        a_ext = a;
        b_ext = b;
        if (word_eff) begin
            a_ext = a_signed ? sext32(a[31:0]) : XLEN'(a[31:0]);
            b_ext = b_signed ? sext32(b[31:0]) : XLEN'(b[31:0]);
        end
        neg_a  = a_signed && (word_eff ? a[31] : a[XLEN-1]);
        neg_b  = b_signed && (word_eff ? b[31] : b[XLEN-1]);
        b_zero = word_eff ? (b[31:0] == 32'd0) : (b == '0);
        b_ones = word_eff ? (&b[31:0]) : (&b);
        a_min  = word_eff ? (a[31:0] == 32'h8000_0000)
                          : (a == {1'b1, {(XLEN-1){1'b0}}});
        fast_dz = op[2] && b_zero;
        fast_ov = div_signed && a_min && b_ones && !b_zero;
    end

    // One iteration step, plus the sign-corrected result selection
    logic [2*XLEN-1:0] mul_add, mul_next, div_next, prod_fix;
    logic [XLEN:0]     rem_sh, diff;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

    always_comb begin
        mul_add  = mb_q[cnt_q] ? {{XLEN{1'b0}}, ma_q} : '0;
        mul_next = (acc_q << 1) + mul_add;

        rem_sh = {acc_q[2*XLEN-1:XLEN], ma_q[cnt_q]};
        diff   = rem_sh - {1'b0, mb_q};
        if (!diff[XLEN]) begin
            div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end

        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (op_q)
            OP_MUL:                       fin_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = word_q ? XLEN'(prod_fix[63:32])
                                                           : prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin_res = quo_fix;
            OP_REM, OP_REMU:              fin_res = rem_fix;
            default:                      fin_res = '0;
        endcase
        if (word_q) begin
            fin_res = sext32(fin_res[31:0]);
        end
    end

    // Fast paths enter CALC with last_q set so they share the finalise cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    state_d = CALC;
                    op_d    = op;
                    word_d  = word_eff;
                    ma_d    = neg_a ? -a_ext : a_ext;
                    mb_d    = neg_b ? -b_ext : b_ext;
                    if (fast_dz || fast_ov) begin
                        neg_a_d = 1'b0;
                        neg_b_d = 1'b0;
                        cnt_d   = '0;
                        last_d  = 1'b1;
                        acc_d   = fast_dz ? {a_ext, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_ext};
                    end else begin
                        neg_a_d = neg_a;
                        neg_b_d = neg_b;
                        cnt_d   = word_eff ? CW'(31) : CW'(XLEN - 1);
                        last_d  = 1'b0;
                        acc_d   = '0;
                    end
                end
            end
            CALC: begin
                if (!last_q) begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    result_d = fin_res;
                    last_d   = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - table-driven scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic        is_word = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int n_pass = 0;
    int n_total = 0;
    logic [63:0] sb_q[$];

    muldiv_unit #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_word(is_word), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                          input logic [63:0] va, input logic [63:0] vb);
        logic signed [127:0] sa, sb;
        logic [127:0] up;
        logic [31:0]  r32;
        int           x32, y32;
        longint       x, y;
        logic [63:0]  r;
        r = '0;
        if (w) begin
            x32 = va[31:0];
            y32 = vb[31:0];
            r32 = '0;
            case (o)
                3'd0: r32 = va[31:0] * vb[31:0];
                3'd4: if (y32 == 0) r32 = '1;
                      else if (x32 == 32'sh8000_0000 && y32 == -1) r32 = va[31:0];
                      else r32 = x32 / y32;
                3'd5: if (y32 == 0) r32 = '1; else r32 = va[31:0] / vb[31:0];
                3'd6: if (y32 == 0) r32 = va[31:0];
                      else if (x32 == 32'sh8000_0000 && y32 == -1) r32 = '0;
                      else r32 = x32 % y32;
                3'd7: if (y32 == 0) r32 = va[31:0]; else r32 = va[31:0] % vb[31:0];
                default: r32 = '0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        x = va;
        y = vb;
        case (o)
            3'd0: r = va * vb;
            3'd1: begin sa = $signed(va); sb = $signed(vb); up = sa * sb; r = up[127:64]; end
            3'd2: begin sa = $signed(va); sb = {64'd0, vb}; up = sa * sb; r = up[127:64]; end
            3'd3: begin up = {64'd0, va} * {64'd0, vb}; r = up[127:64]; end
            3'd4: if (y == 0) r = '1;
                  else if (va == 64'h8000_0000_0000_0000 && y == -1) r = va;
                  else r = x / y;
            3'd5: if (y == 0) r = '1; else r = va / vb;
            3'd6: if (y == 0) r = va;
                  else if (va == 64'h8000_0000_0000_0000 && y == -1) r = '0;
                  else r = x % y;
            3'd7: if (y == 0) r = va; else r = va % vb;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] va,
                          input logic [63:0] vb, input logic [63:0] ve, input int vlat,
                          input int hold, input string tag);
        int lat;
        logic [63:0] exp_r;
        @(negedge clk);
        check({tag, " in_ready"}, in_ready, 1);
        op = o; is_word = w; a = va; b = vb; in_valid = 1'b1;
        sb_q.push_back(ve);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom_range(0, 7));
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(vlat));
        exp_r = sb_q.pop_front();
        check({tag, " result"}, result, exp_r);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold_result"}, result, exp_r);
            check({tag, " hold_in_ready"}, {63'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " handoff"}, {63'd0, out_valid}, 0);
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    initial begin
        tbl[0]  = '{3'd0, 1'b0, 64'd6, 64'd5, 64'd30, 65, 5};
        tbl[1]  = '{3'd1, 1'b0, ONES, 64'd2, ONES, 65, 0};
        tbl[2]  = '{3'd3, 1'b0, ONES, 64'd2, 64'd1, 65, 0};
        tbl[3]  = '{3'd2, 1'b0, ONES, 64'd2, ONES, 65, 0};
        tbl[4]  = '{3'd4, 1'b0, -64'd7, 64'd2, -64'd3, 65, 0};
        tbl[5]  = '{3'd6, 1'b0, -64'd7, 64'd2, -64'd1, 65, 0};
        tbl[6]  = '{3'd5, 1'b0, 64'd66, 64'd11, 64'd6, 65, 0};
        tbl[7]  = '{3'd7, 1'b0, 64'd62, 64'd3, 64'd2, 65, 0};
        tbl[8]  = '{3'd4, 1'b0, 64'd42, 64'd0, ONES, 1, 0};
        tbl[9]  = '{3'd6, 1'b0, 64'd42, 64'd0, 64'd42, 1, 0};
        tbl[10] = '{3'd4, 1'b0, MIN, ONES, MIN, 1, 0};
        tbl[11] = '{3'd6, 1'b0, MIN, ONES, 64'd0, 1, 0};
        tbl[12] = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0};
        tbl[13] = '{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, ONES, 33, 0};
        tbl[14] = '{3'd6, 1'b1, 64'hAAAA_0000_FFFF_FFF9, 64'h1234_0000_0000_0000, -64'd7, 1, 0};
        tbl[15] = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0};

        #12;
        check("reset out_valid", {63'd0, out_valid}, 0);
        check("reset in_ready", {63'd0, in_ready}, 1);
        check("reset result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat,
                   tbl[i].hold, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            logic [2:0] o;
            logic w, bz, ov;
            logic [63:0] va, vb;
            int n;
            o  = 3'($urandom_range(0, 7));
            w  = (o == 3'd0 || o[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            va = {$urandom, $urandom};
            vb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            n  = w ? 32 : 64;
            bz = w ? (vb[31:0] == 0) : (vb == 0);
            ov = (o == 3'd4 || o == 3'd6) &&
                 (w ? (va[31:0] == 32'h8000_0000 && &vb[31:0]) : (va == MIN && vb == ONES));
            run_op(o, w, va, vb, model(o, w, va, vb), (o[2] && (bz || ov)) ? 1 : n + 1, 0,
                   $sformatf("rnd%0d", i));
        end

        // flush ten cycles into CALC, with a competing request in the same cycle
        @(negedge clk);
        op = 3'd0; is_word = 1'b0; a = 64'd6; b = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1; op = 3'd5; a = 64'd9; b = 64'd3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", {63'd0, out_valid}, 0);
        check("flush in_ready", {63'd0, in_ready}, 1);
        begin
            int seen;
            seen = 0;
            repeat (70) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("flush no_result", 64'(seen), 0);
        end
        run_op(3'd5, 1'b0, 64'd66, 64'd11, 64'd6, 65, 0, "post_flush");

        // asynchronous reset while DONE
        @(negedge clk);
        op = 3'd4; is_word = 1'b0; a = 64'd42; b = 64'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset out_valid", {63'd0, out_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset out_valid", {63'd0, out_valid}, 0);
        check("async_reset in_ready", {63'd0, in_ready}, 1);
        check("async_reset result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd6, 1'b0, -64'd7, 64'd2, -64'd1, 65, 0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
